// File: rtl/sdram_rd_frontend_if.sv
// Request/response and sequencer-side signal bundle for the SDRAM read front end.
// slave is the front end's view; master is the view of whoever drives it (upstream plus sequencer).
interface sdram_rd_frontend_if #(
    parameter int DB_WIDTH = 16,
    parameter int DSIZE    = 4
);
    logic                      ivalid;
    logic [24:0]               iaddr;
    logic                      oready;
    logic                      iinval;
    logic                      ovalid;
    logic                      iready;
    logic [DB_WIDTH-1:0]       oword;
    logic [DB_WIDTH*DSIZE-1:0] oline;
    logic                      ohit;
    logic                      oerr;
    logic                      oreq;
    logic                      oenb;
    logic [12:0]               orow;
    logic [9:0]                ocolumn;
    logic [1:0]                obank;
    logic                      ifin;
    logic [DB_WIDTH*DSIZE-1:0] idata;

    modport slave (
        input  ivalid, iaddr, iinval, iready, ifin, idata,
        output oready, ovalid, oword, oline, ohit, oerr, oreq, oenb, orow, ocolumn, obank
    );

    modport master (
        output ivalid, iaddr, iinval, iready, ifin, idata,
        input  oready, ovalid, oword, oline, ohit, oerr, oreq, oenb, orow, ocolumn, obank
    );
endinterface

// File: rtl/sdram_rd_frontend.sv
// Read request front end: address split, sequencer handshake with watchdog, and a
// one-line buffer that answers repeat reads of the same burst line without an SDRAM access.
module sdram_rd_frontend #(
    parameter int DB_WIDTH = 16,
    parameter int DSIZE    = 4,
    parameter int TIMEOUT  = 255
) (
    input logic               iclk,
    input logic               ctr_reset,
    sdram_rd_frontend_if.slave bus
);
    localparam int LW     = $clog2(DSIZE);
    localparam int LINE_W = DB_WIDTH * DSIZE;
    localparam int TAG_W  = 25 - LW;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state;
    logic [7:0]        timer;
    logic [12:0]       row;
    logic [1:0]        bank;
    logic [9:0]        column;
    logic [LW-1:0]     offset;
    logic              hit_q;
    logic              err_q;
    logic              line_valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;

    logic hit;
    logic fill;
    logic timeout;
    logic [LW-1:0] widx;

    // A same-cycle invalidate wins over the tag match, so the request goes to SDRAM.
    assign hit     = line_valid && !bus.iinval && (tag == bus.iaddr[24:LW]);
    assign fill    = (state == S_WAIT) && bus.ifin;
    assign timeout = (state == S_WAIT) && !bus.ifin && (timer == TMO);

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            state  <= S_IDLE;
            timer  <= '0;
            row    <= '0;
            bank   <= '0;
            column <= '0;
            offset <= '0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ivalid) begin
                        row    <= bus.iaddr[24:12];
                        bank   <= bus.iaddr[11:10];
                        column <= {bus.iaddr[9:LW], {LW{1'b0}}};
                        offset <= bus.iaddr[LW-1:0];
                        hit_q  <= hit;
                        err_q  <= 1'b0;
                        state  <= hit ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 8'd1;
                    if (bus.ifin) begin
                        state <= S_RESP;
                    end else if (timer == TMO) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.iready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The captured line is kept even if invalidated: the in-flight response still reads it.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            line_valid <= 1'b0;
            tag        <= '0;
            line       <= '0;
        end else begin
            if (fill) begin
                line <= bus.idata;
                tag  <= {row, bank, column[9:LW]};
            end
            if (bus.iinval || timeout) line_valid <= 1'b0;
            else if (fill)             line_valid <= 1'b1;
        end
    end

    // First word sits in the MSBs, so word index DSIZE-1-offset is the bitwise inverse.
    assign widx = ~offset;

    assign bus.oready  = (state == S_IDLE);
    assign bus.ovalid  = (state == S_RESP);
    assign bus.oreq    = (state == S_ISSUE);
    assign bus.oenb    = (state == S_ISSUE) || (state == S_WAIT);
    assign bus.oword   = line[int'(widx)*DB_WIDTH +: DB_WIDTH];
    assign bus.oline   = line;
    assign bus.ohit    = hit_q;
    assign bus.oerr    = err_q;
    assign bus.orow    = row;
    assign bus.obank   = bank;
    assign bus.ocolumn = column;
endmodule

// File: tb/tb_sdram_rd_frontend.sv
// Bench for sdram_rd_frontend: directed pinned cases, then randomized traffic
// against a transaction-level line-buffer model checked every cycle.
module tb_sdram_rd_frontend;
    localparam int DB_WIDTH = 16;
    localparam int DSIZE    = 4;
    localparam int TIMEOUT  = 255;
    localparam int LW       = $clog2(DSIZE);
    localparam int LINE_W   = DB_WIDTH * DSIZE;

    logic iclk;
    logic ctr_reset;

    sdram_rd_frontend_if #(.DB_WIDTH(DB_WIDTH), .DSIZE(DSIZE)) bus ();

    sdram_rd_frontend #(.DB_WIDTH(DB_WIDTH), .DSIZE(DSIZE), .TIMEOUT(TIMEOUT)) dut (
        .iclk      (iclk),
        .ctr_reset (ctr_reset),
        .bus       (bus)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one-line buffer plus the expected visible outputs of the current cycle
    bit                lb_v = 1'b0;
    logic [24-LW:0]    lb_tag = '0;
    logic [LINE_W-1:0] lb_data = '0;

    bit                chk_en = 1'b0;
    bit                noisy  = 1'b0;
    logic              exp_oready, exp_ovalid, exp_oreq, exp_oenb, exp_ohit, exp_oerr;
    logic [12:0]       exp_orow;
    logic [1:0]        exp_obank;
    logic [9:0]        exp_ocol;
    logic [DB_WIDTH-1:0] exp_oword;
    logic [LINE_W-1:0] exp_oline;

    int                oreq_cnt;
    int                cap_lat, cap_nreq;
    logic              cap_ohit, cap_oerr;
    logic [DB_WIDTH-1:0] cap_oword;
    logic [12:0]       cap_orow;
    logic [1:0]        cap_obank;
    logic [9:0]        cap_ocol;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic exp_reset();
        exp_oready = 1'b1; exp_ovalid = 1'b0; exp_oreq = 1'b0; exp_oenb = 1'b0;
        exp_ohit = 1'b0; exp_oerr = 1'b0; exp_orow = '0; exp_obank = '0; exp_ocol = '0;
        exp_oword = '0; exp_oline = '0;
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
        if (bus.oreq) oreq_cnt++;
    endtask

    task automatic busy_noise();
        if (noisy) begin
            bus.ivalid = 1'($urandom_range(0, 1));
            bus.iaddr  = 25'($urandom);
            bus.iinval = ($urandom_range(0, 15) == 0);
            bus.iready = 1'($urandom_range(0, 1));
        end else begin
            bus.ivalid = 1'b0;
            bus.iinval = 1'b0;
            bus.iready = 1'b0;
        end
    endtask

    // Runs one read from an IDLE cycle to the next IDLE cycle. fin_dly: WAIT cycle index
    // at which the sequencer answers, or -1 for never.
    task automatic run_req(input logic [24:0] a, input bit inv_acc, input int fin_dly,
                           input int stall, input logic [LINE_W-1:0] d);
        bit hit, err;
        int k, lat;
        logic [LINE_W-1:0] rline;
        logic [LW-1:0] off;
        bus.ivalid = 1'b1; bus.iaddr = a; bus.iinval = inv_acc; bus.iready = 1'b0;
        if (inv_acc) lb_v = 1'b0;
        hit = lb_v && (lb_tag == a[24:LW]);
        oreq_cnt = 0;
        err = 1'b0;
        rline = lb_data;
        step(); lat = 1;
        exp_oready = 1'b0;
        exp_orow = a[24:12]; exp_obank = a[11:10]; exp_ocol = {a[9:LW], {LW{1'b0}}};
        off = a[LW-1:0];
        if (!hit) begin
            exp_oreq = 1'b1; exp_oenb = 1'b1;
            busy_noise();
            step(); lat++;
            if (bus.iinval) lb_v = 1'b0;
            exp_oreq = 1'b0;
            k = 0;
            forever begin
                busy_noise();
                bus.ifin  = (k == fin_dly);
                bus.idata = bus.ifin ? d : {$urandom, $urandom};
                step(); lat++;
                if (bus.ifin) begin
                    rline = d; lb_data = d; lb_tag = a[24:LW]; lb_v = !bus.iinval;
                    break;
                end
                if (k == TIMEOUT) begin
                    err = 1'b1; lb_v = 1'b0;
                    break;
                end
                if (bus.iinval) lb_v = 1'b0;
                k++;
            end
            bus.ifin = 1'b0;
            exp_oenb = 1'b0;
        end
        exp_ovalid = 1'b1; exp_ohit = hit; exp_oerr = err; exp_oline = rline;
        exp_oword = rline[(DSIZE - 1 - int'(off)) * DB_WIDTH +: DB_WIDTH];
        cap_lat = lat; cap_nreq = oreq_cnt; cap_ohit = bus.ohit; cap_oerr = bus.oerr;
        cap_oword = bus.oword; cap_orow = bus.orow; cap_obank = bus.obank; cap_ocol = bus.ocolumn;
        for (int s = 0; s < stall; s++) begin
            busy_noise();
            bus.iready = 1'b0;
            step();
            if (bus.iinval) lb_v = 1'b0;
        end
        busy_noise();
        bus.iready = 1'b1;
        step();
        if (bus.iinval) lb_v = 1'b0;
        bus.ivalid = 1'b0; bus.iinval = 1'b0; bus.iready = 1'b0;
        exp_ovalid = 1'b0; exp_oready = 1'b1;
    endtask

    task automatic idle_cycle(input bit inv);
        bus.ivalid = 1'b0; bus.iinval = inv;
        step();
        if (inv) lb_v = 1'b0;
        bus.iinval = 1'b0;
    endtask

    always @(negedge iclk) begin
        if (chk_en) begin
            chk("oready", bus.oready, exp_oready);
            chk("ovalid", bus.ovalid, exp_ovalid);
            chk("oreq", bus.oreq, exp_oreq);
            chk("oenb", bus.oenb, exp_oenb);
            chk("orow", bus.orow, exp_orow);
            chk("obank", bus.obank, exp_obank);
            chk("ocolumn", bus.ocolumn, exp_ocol);
            if (exp_ovalid) begin
                chk("ohit", bus.ohit, exp_ohit);
                chk("oerr", bus.oerr, exp_oerr);
                if (!exp_oerr) begin
                    chk("oword", bus.oword, exp_oword);
                    chk("oline", bus.oline, exp_oline);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] a;
        int fd;
        ctr_reset = 1'b1;
        bus.ivalid = 1'b0; bus.iaddr = '0; bus.iinval = 1'b0; bus.iready = 1'b0;
        bus.ifin = 1'b0; bus.idata = '0;
        exp_reset();
        repeat (2) @(posedge iclk);
        #1;
        chk("reset_oready", bus.oready, 1'b1);
        chk("reset_ovalid", bus.ovalid, 1'b0);
        chk("reset_oenb", bus.oenb, 1'b0);
        chk("reset_oline", bus.oline, '0);
        ctr_reset = 1'b0;
        step();
        chk_en = 1'b1;

        // Miss on a fresh buffer
        run_req(25'h0001235, 1'b0, 2, 0, 64'h1111_2222_3333_4444);
        chk("miss_orow", cap_orow, 13'h1);
        chk("miss_obank", cap_obank, 2'h0);
        chk("miss_ocol", cap_ocol, 10'h234);
        chk("miss_oword", cap_oword, 16'h2222);
        chk("miss_ohit", cap_ohit, 1'b0);
        chk("miss_oerr", cap_oerr, 1'b0);
        chk("miss_nreq", cap_nreq, 1);
        chk("miss_lat", cap_lat, 5);

        // Same line, other word
        run_req(25'h0001236, 1'b0, 0, 0, '0);
        chk("hit_oword", cap_oword, 16'h3333);
        chk("hit_ohit", cap_ohit, 1'b1);
        chk("hit_nreq", cap_nreq, 0);
        chk("hit_lat", cap_lat, 1);

        // Invalidate pulse, then invalidate coincident with accept
        idle_cycle(1'b1);
        run_req(25'h0001236, 1'b0, 1, 0, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("inval_ohit", cap_ohit, 1'b0);
        chk("inval_nreq", cap_nreq, 1);
        chk("inval_oword", cap_oword, 16'hCCCC);
        run_req(25'h0001237, 1'b1, 0, 0, 64'h0102_0304_0506_0708);
        chk("invacc_ohit", cap_ohit, 1'b0);
        chk("invacc_nreq", cap_nreq, 1);
        chk("invacc_oword", cap_oword, 16'h0708);

        // Backpressure on a hit
        run_req(25'h0001234, 1'b0, 0, 5, '0);
        chk("bp_oword", cap_oword, 16'h0102);

        // Watchdog, then ifin on the last allowed WAIT cycle
        run_req(25'h0008010, 1'b0, -1, 0, '0);
        chk("tmo_oerr", cap_oerr, 1'b1);
        chk("tmo_lat", cap_lat, TIMEOUT + 3);
        run_req(25'h0008010, 1'b0, TIMEOUT, 1, 64'h5555_6666_7777_8888);
        chk("edge_oerr", cap_oerr, 1'b0);
        chk("edge_ohit", cap_ohit, 1'b0);
        chk("edge_lat", cap_lat, TIMEOUT + 3);
        chk("edge_oword", cap_oword, 16'h5555);

        // Reset asserted mid-cycle while waiting on the sequencer
        chk_en = 1'b0;
        bus.ivalid = 1'b1; bus.iaddr = 25'h0004321;
        step();
        bus.ivalid = 1'b0;
        step(); step(); step();
        chk("prerst_oenb", bus.oenb, 1'b1);
        #3;
        ctr_reset = 1'b1;
        #1;
        chk("rst_oready", bus.oready, 1'b1);
        chk("rst_ovalid", bus.ovalid, 1'b0);
        chk("rst_oreq", bus.oreq, 1'b0);
        chk("rst_oenb", bus.oenb, 1'b0);
        chk("rst_orow", bus.orow, 13'h0);
        @(negedge iclk);
        ctr_reset = 1'b0;
        step();
        exp_reset();
        lb_v = 1'b0;
        chk_en = 1'b1;
        run_req(25'h0001236, 1'b0, 0, 0, 64'h9999_AAAA_BBBB_CCCC);
        chk("postrst_ohit", cap_ohit, 1'b0);
        chk("postrst_nreq", cap_nreq, 1);

        // Randomized traffic over a small address pool so hits are frequent
        noisy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            a = {13'($urandom_range(0, 1)), 2'($urandom_range(0, 1) * 3), 10'($urandom_range(0, 11))};
            fd = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 6));
            run_req(a, ($urandom_range(0, 9) == 0), fd, int'($urandom_range(0, 3)),
                    {$urandom, $urandom});
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                idle_cycle($urandom_range(0, 7) == 0);
        end
        noisy = 1'b0;
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
